// File: rtl/quad_decode_counter_if.sv
// Encoder phases, counter controls and position outputs of quad_decode_counter.
// The master side drives the encoder and controls; the slave side is the decoder.
interface quad_decode_counter_if #(
  parameter int WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic             clr;
  logic             ld;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  modport master (
    output enc_a, enc_b, clr, ld, d_in,
    input  count, dir, step, err
  );

  modport slave (
    input  enc_a, enc_b, clr, ld, d_in,
    output count, dir, step, err
  );
endinterface

// File: rtl/quad_decode_counter.sv
// Quadrature decoder: synchronizes encoder phases A/B, decodes Gray-code steps
// and keeps a modulo-2^WIDTH position count with clear/load and a sticky error.
module quad_decode_counter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  quad_decode_counter_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic [1:0]             state_s;
  logic [1:0]             prev;
  logic                   primed;
  logic [1:0]             delta;
  logic                   step_up;
  logic                   step_dn;
  logic                   illegal;
  logic [WIDTH-1:0]       count_q;
  logic                   dir_q;
  logic                   step_q;
  logic                   err_q;

  // Position of a Gray state along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  assign state_s = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign delta   = gray_pos(state_s) - gray_pos(prev);
  assign step_up = primed && (delta == 2'd1);
  assign step_dn = primed && (delta == 2'd3);
  assign illegal = primed && (delta == 2'd2);

  // sync_vld marks when the last stage holds a real sample rather than its
  // reset value; priming waits for it so an encoder resting at 11 across
  // reset is not mistaken for a 00->11 jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= '0;
      sync_b   <= '0;
      sync_vld <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value on the same edge, which is what makes a shift chain.
      sync_a   <= {sync_a[SYNC_STAGES-2:0], bus.enc_a};
      sync_b   <= {sync_b[SYNC_STAGES-2:0], bus.enc_b};
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= 2'b00;
      primed  <= 1'b0;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (sync_vld[SYNC_STAGES-1]) begin
        prev   <= state_s;
        primed <= 1'b1;
      end

      step_q <= step_up | step_dn;
      if (step_up)      dir_q <= 1'b1;
      else if (step_dn) dir_q <= 1'b0;

      // clr beats ld beats the decoded step; a dropped step is never replayed
      // because prev has already moved on.
      if (bus.clr) begin
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (illegal) err_q <= 1'b1;
        if (bus.ld)       count_q <= bus.d_in;
        else if (step_up) count_q <= count_q + WIDTH'(1);
        else if (step_dn) count_q <= count_q - WIDTH'(1);
      end
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decode_counter.sv
// Randomized bench for quad_decode_counter: a delay-queue reference model is
// compared every cycle, plus directed sequences with hand-computed values.
module tb_quad_decode_counter;
  localparam int W  = 8;
  localparam int SS = 2;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_seen = 0;
  int   pos = 0;
  logic [1:0] gray_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_decode_counter_if #(.WIDTH(W)) bus ();

  quad_decode_counter #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs reach the decoder SS edges after being sampled;
  // each sample is tagged with whether it is real or just reset fill.
  typedef struct {
    logic       v;
    logic [1:0] ab;
  } samp_t;

  samp_t      q[$];
  samp_t      s;
  logic [1:0] m_prev;
  logic       m_primed;
  logic [W-1:0] m_count;
  logic       m_dir, m_step, m_err;
  int         d;

  function automatic int idx_of(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (gray_seq[i] == ab) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_prev = 2'b00; m_primed = 1'b0;
      m_count = '0; m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0;
    end else begin
      while (q.size() < SS) q.push_front('{1'b0, 2'b00});
      s = q.pop_front();
      q.push_back('{1'b1, {bus.enc_a, bus.enc_b}});
      d = 0;
      if (s.v) begin
        if (m_primed) d = (idx_of(s.ab) - idx_of(m_prev) + 4) % 4;
        m_primed = 1'b1;
        m_prev   = s.ab;
      end
      m_step = (d == 1) || (d == 3);
      if (d == 1) m_dir = 1'b1;
      if (d == 3) m_dir = 1'b0;
      if (bus.clr) begin
        m_count = '0;
        m_err   = 1'b0;
      end else begin
        if (d == 2) m_err = 1'b1;
        if (bus.ld)      m_count = bus.d_in;
        else if (d == 1) m_count = m_count + 1'b1;
        else if (d == 3) m_count = m_count - 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("count", bus.count, m_count);
    check("dir",   bus.dir,   m_dir);
    check("step",  bus.step,  m_step);
    check("err",   bus.err,   m_err);
    if (bus.step === 1'b1) step_seen++;
  end

  task automatic drive_ab(input logic [1:0] ab, input int hold);
    @(negedge clk);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic step_fwd();
    pos = (pos + 1) % 4;
    drive_ab(gray_seq[pos], 4);
  endtask

  task automatic step_rev();
    pos = (pos + 3) % 4;
    drive_ab(gray_seq[pos], 4);
  endtask

  task automatic pulse_clr();
    @(negedge clk) bus.clr = 1'b1;
    @(negedge clk) bus.clr = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    @(negedge clk);
    bus.ld = 1'b1;
    bus.d_in = v;
    @(negedge clk) bus.ld = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int hold;
    int r;
    rst_n = 1'b0;
    bus.enc_a = 1'b0; bus.enc_b = 1'b0;
    bus.clr = 1'b0; bus.ld = 1'b0; bus.d_in = '0;
    repeat (3) @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_dir",   bus.dir,   0);
    check("rst_step",  bus.step,  0);
    check("rst_err",   bus.err,   0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 16 forward steps
    s0 = step_seen;
    for (int i = 0; i < 16; i++) step_fwd();
    check("fwd16_count", bus.count, 16);
    check("fwd16_dir",   bus.dir,   1);
    check("fwd16_err",   bus.err,   0);
    check("fwd16_pulses", step_seen - s0, 16);

    // reverse across zero
    pulse_clr();
    check("clr_count", bus.count, 0);
    step_rev(); check("rev1_count", bus.count, 255);
    step_rev(); check("rev2_count", bus.count, 254);
    step_rev(); check("rev3_count", bus.count, 253);
    check("rev_dir", bus.dir, 0);
    step_rev(); check("rev4_count", bus.count, 252);

    // upward wrap
    load(8'd254);
    check("ld254_count", bus.count, 254);
    step_fwd(); check("wrap_255", bus.count, 255);
    step_fwd(); check("wrap_0", bus.count, 0);

    // encoder resting at 11 through reset
    pos = 2;
    drive_ab(2'b11, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("prime11_count", bus.count, 0);
    check("prime11_err",   bus.err,   0);
    step_fwd();
    check("prime11_step_count", bus.count, 1);
    check("prime11_step_err",   bus.err,   0);

    // illegal 00->11 jump, then clear
    step_fwd();
    check("pre_illegal_count", bus.count, 2);
    s0 = step_seen;
    pos = 2;
    drive_ab(2'b11, 4);
    check("illegal_err",    bus.err,   1);
    check("illegal_count",  bus.count, 2);
    check("illegal_nostep", step_seen - s0, 0);
    pulse_clr();
    check("clr_err",   bus.err,   0);
    check("clr_count", bus.count, 0);

    // load colliding with a decoded step
    pos = 3;
    @(negedge clk);
    bus.enc_a = 1'b1; bus.enc_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.ld = 1'b1; bus.d_in = 8'd100;
    @(posedge clk);
    #1 check("ld_step_pulse", bus.step, 1);
    @(negedge clk) bus.ld = 1'b0;
    check("ld_step_count", bus.count, 100);
    step_fwd();
    check("ld_next_count", bus.count, 101);

    // reset mid-operation
    for (int i = 0; i < 10; i++) step_fwd();
    check("pre_rst_count", bus.count, 111);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_dir",   bus.dir,   0);
    check("async_rst_step",  bus.step,  0);
    check("async_rst_err",   bus.err,   0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_count", bus.count, 0);
    check("post_rst_err",   bus.err,   0);

    // randomized walk with occasional illegal jumps, clears and loads
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      pos = (pos + 1) % 4;
      else if (r < 90) pos = (pos + 3) % 4;
      else if (r < 95) pos = (pos + 2) % 4;
      hold = $urandom_range(SS + 1, 6);
      @(negedge clk);
      bus.enc_a = gray_seq[pos][1];
      bus.enc_b = gray_seq[pos][0];
      for (int i = 0; i < hold; i++) begin
        bus.clr  = ($urandom_range(0, 29) == 0);
        bus.ld   = ($urandom_range(0, 14) == 0);
        bus.d_in = W'($urandom);
        if (i < hold - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    bus.clr = 1'b0; bus.ld = 1'b0;
    pulse_clr();
    repeat (2) @(negedge clk);
    check("final_err", bus.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
